mcs4_rom_reader: RTL and testbench

MCS4_ROM_READER -- requirements
Module: mcs4_rom_reader

---
 rtl/mcs4_rom_reader.sv | 121 ++++++++++++
 tb/tb_mcs4_rom_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_rom_reader.sv
// rtl/mcs4_rom_reader.sv - MCS-4 bus master fetching bursts of 8-bit words from i4001 ROMs
module mcs4_rom_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        clken_1,
    input  logic        clken_2,
    output logic        sync,
    output logic        cm_rom,
    input  logic [3:0]  dbus_in,
    output logic [3:0]  dbus_out,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_addr,
    input  logic [3:0]  req_len,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_last,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X3 = 3'd7;

    state_t      state, state_next;
    logic [2:0]  phase;
    logic [11:0] addr;
    logic [4:0]  remaining;
    logic [3:0]  opr;
    logic        wait_wrap;
    logic        wrap;
    logic        unused_clken_1;

    // Phase 1 carries no information for a pure ROM reader; everything keys off phase 2.
    assign unused_clken_1 = clken_1;
    assign wrap = clken_2 && (phase == PH_X3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PH_A1;
        end else if (clken_2) begin
            phase <= phase + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ARMED;
            ARMED:   if (wrap && !wait_wrap) state_next = ACTIVE;
            ACTIVE:  if (wrap && remaining == 5'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        sync      = (phase == PH_X3);
        cm_rom    = (state == ACTIVE) && (phase == PH_A3);
        dbus_out  = 4'd0;
        if (state == ACTIVE) begin
            case (phase)
                PH_A1:   dbus_out = addr[3:0];
                PH_A2:   dbus_out = addr[7:4];
                PH_A3:   dbus_out = addr[11:8];
                default: dbus_out = 4'd0;
            endcase
        end
    end

    // A request taken mid-X3 (before its clken_2) must let that X3->A1 pass before starting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= 12'd0;
            remaining <= 5'd0;
            wait_wrap <= 1'b0;
            opr       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
            rsp_last  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            if (state == IDLE && req_valid) begin
                addr      <= req_addr;
                remaining <= (req_len == 4'd0) ? 5'd16 : {1'b0, req_len};
                wait_wrap <= (phase == PH_X3) && !clken_2;
            end
            if (state == ARMED && wrap) begin
                wait_wrap <= 1'b0;
            end
            if (state == ACTIVE && clken_2) begin
                if (phase == PH_M1) begin
                    opr <= dbus_in;
                end
                if (phase == PH_M2) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= {opr, dbus_in};
                    rsp_last  <= (remaining == 5'd1);
                    addr      <= addr + 12'd1;
                    remaining <= remaining - 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcs4_rom_reader.sv
// tb/tb_mcs4_rom_reader.sv - scoreboard bench for mcs4_rom_reader against an i4001 ROM model
module tb_mcs4_rom_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clken_1, clken_2;
    logic        sync, cm_rom;
    logic [3:0]  dbus_in, dbus_out;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = 12'd0;
    logic [3:0]  req_len = 4'd0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_last;
    logic        busy;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         first_c2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [1:0] cnt = 2'd0;
    logic [2:0] tb_phase;
    int   c2count = 0;
    logic [3:0] a0, a1, a2;
    logic [7:0] rom_byte;

    mcs4_rom_reader dut (
        .clk       (clk),
        .rst       (rst),
        .clken_1   (clken_1),
        .clken_2   (clken_2),
        .sync      (sync),
        .cm_rom    (cm_rom),
        .dbus_in   (dbus_in),
        .dbus_out  (dbus_out),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 2'd1;
    assign clken_1 = (cnt == 2'd0);
    assign clken_2 = (cnt == 2'd2);

    always @(posedge clk) if (clken_2) c2count <= c2count + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_phase <= 3'd0;
        else if (clken_2) tb_phase <= tb_phase + 3'd1;
    end

    function automatic logic [7:0] rom_val(input logic [11:0] a);
        case (a)
            12'h012: return 8'hA5;
            12'hFFE: return 8'h3C;
            12'hFFF: return 8'h7E;
            12'h000: return 8'h81;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // i4001 model: gathers the address nibbles, the chip select nibble only with cm_rom.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a0 <= 4'd0;
            a1 <= 4'd0;
            a2 <= 4'd0;
        end else if (clken_2) begin
            case (tb_phase)
                3'd0:    a0 <= dbus_out;
                3'd1:    a1 <= dbus_out;
                3'd2:    a2 <= cm_rom ? dbus_out : 4'hF;
                default: ;
            endcase
        end
    end
    assign rom_byte = rom_val({a2, a1, a0});
    assign dbus_in  = (tb_phase == 3'd3) ? rom_byte[7:4] :
                      (tb_phase == 3'd4) ? rom_byte[3:0] : 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l, input int f);
        exp_t e;
        e.data = d;
        e.last = l;
        e.first_c2 = f;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [11:0] a, input logic [3:0] l, input bit at_x3, output int acc_c2);
        int n = 0;
        @(negedge clk);
        while ((!req_ready || (at_x3 && !(tb_phase == 3'd7 && cnt == 2'd0))) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("issue_wait", n < 1000, 1);
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_c2 = c2count;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 3000, 1);
    endtask

    // Monitor: scoreboard pops plus always-true bus invariants.
    initial begin
        exp_t e;
        bit   have_prev = 0;
        bit   prev_last = 0;
        int   prev_c2 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_prev = 0;
            end else begin
                chk("sync_phase", sync, tb_phase == 3'd7);
                if (tb_phase > 3'd2) chk("dbus_released", dbus_out, 4'd0);
                if (cm_rom) chk("cm_rom_in_a3", tb_phase, 3'd2);
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got data %0h with no response expected", rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_last", rsp_last, e.last);
                        if (e.first_c2 >= 0) chk("first_word_c2", c2count, e.first_c2);
                        if (have_prev && !prev_last) chk("word_gap_c2", c2count - prev_c2, 8);
                    end
                    have_prev = 1;
                    prev_last = rsp_last;
                    prev_c2 = c2count;
                end
            end
        end
    end

    initial begin
        int acc;
        int syncs;
        logic prev_sync;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sync", sync, 0);
        chk("rst_cm_rom", cm_rom, 0);
        chk("rst_dbus_out", dbus_out, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("req_ready_after_rst", req_ready, 1);

        // Idle: five instruction cycles.
        while (tb_phase != 3'd0) @(negedge clk);
        syncs = 0;
        prev_sync = 1'b0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (sync && !prev_sync) syncs++;
            prev_sync = sync;
            if (clken_2) begin
                chk("idle_dbus", dbus_out, 0);
                chk("idle_cm_rom", cm_rom, 0);
            end
        end
        chk("idle_sync_count", syncs, 5);

        // Single read.
        push(8'hA5, 1'b1, -1);
        issue(12'h012, 4'd1, 0, acc);
        drain();
        chk("single_idle", req_ready, 1);

        // Address wrap.
        push(8'h3C, 1'b0, -1);
        push(8'h7E, 1'b0, -1);
        push(8'h81, 1'b1, -1);
        issue(12'hFFE, 4'd3, 0, acc);
        drain();

        // len 0 means sixteen words.
        for (int i = 0; i < 16; i++) push(rom_val(12'h200 + 12'(i)), i == 15, -1);
        issue(12'h200, 4'd0, 0, acc);
        drain();

        // Accepted mid-X3, then requests while busy are ignored.
        issue(12'h345, 4'd2, 1, acc);
        push(8'h1F, 1'b0, acc + 14);
        push(8'h1C, 1'b1, -1);
        repeat (4) @(negedge clk);
        req_addr  = 12'h777;
        req_len   = 4'd1;
        req_valid = 1'b1;
        @(negedge clk);
        chk("busy_req_ready", req_ready, 0);
        chk("busy_flag", busy, 1);
        repeat (40) @(negedge clk);
        req_valid = 1'b0;
        drain();

        // Reset during M1 of word 2.
        push(8'h5A, 1'b0, -1);
        issue(12'h100, 4'd4, 0, acc);
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
            while (tb_phase != 3'd3 && n < 1000) begin @(negedge clk); n++; end
            chk("reach_word2_m1", n < 1000, 1);
        end
        rst = 1'b1;
        #1;
        chk("midrst_dbus", dbus_out, 0);
        chk("midrst_cm_rom", cm_rom, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sync", sync, 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("req_ready_after_midrst", req_ready, 1);
        repeat (200) @(negedge clk);
        push(8'hA5, 1'b1, -1);
        issue(12'h012, 4'd1, 0, acc);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
